pc_call_stack: RTL and testbench

//   Parametrised program counter for the SAP-family CPU.
//   - Increments, jumps from the bus, and does CALL/RET through an internal LIFO return-address stack.
//   - Drives its address onto the shared bus on request.
//   - Sits between the control sequencer (ce/co/jmp/call/ret strobes) and the bus / MAR path.

---
 rtl/pc_call_stack.sv | 118 +++++++++++
 tb/tb_pc_call_stack.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pc_call_stack.sv
// Program counter with increment, jump, CALL/RET via an internal return-address stack,
// and a registered bus drive of the pre-update PC.
module pc_call_stack #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce,
    input  logic                             jmp,
    input  logic                             call,
    input  logic                             ret,
    input  logic                             co,
    input  logic [ADDR_W-1:0]                bus_in,
    output logic [ADDR_W-1:0]                pc,
    output logic [ADDR_W-1:0]                bus_out,
    output logic                             bus_oe,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             ovf_err,
    output logic                             unf_err
);
    localparam int SP_W  = $clog2(STACK_DEPTH+1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] bus_out_reg, bus_out_next;
    logic              bus_oe_reg, bus_oe_next;
    logic [SP_W-1:0]   sp_reg, sp_next;
    logic              ovf_reg, ovf_next;
    logic              unf_reg, unf_next;
    logic              push;
    logic              full, empty;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [ADDR_W-1:0] top_addr;
    logic [STACK_DEPTH-1:0] entry_we;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    assign full   = (sp_reg == SP_W'(STACK_DEPTH));
    assign empty  = (sp_reg == '0);
    assign wr_idx = IDX_W'(sp_reg);
    assign rd_idx = IDX_W'(sp_reg - SP_W'(1));
    // Only consumed when the stack is non-empty, so rd_idx is always in range then.
    assign top_addr = stack_mem[rd_idx];

    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_we
            assign entry_we[gi] = push && (wr_idx == IDX_W'(gi));
        end
    endgenerate

    // Return-address storage is deliberately not reset; sp alone defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (entry_we[i]) stack_mem[i] <= pc_reg;
        end
    end

    always_comb begin
        pc_next      = pc_reg;
        sp_next      = sp_reg;
        ovf_next     = ovf_reg;
        unf_next     = unf_reg;
        push         = 1'b0;
        bus_out_next = co ? pc_reg : '0;
        bus_oe_next  = co;
        if (ret) begin
            if (!empty) begin
                pc_next = top_addr;
                sp_next = sp_reg - SP_W'(1);
            end else begin
                unf_next = 1'b1;
            end
        end else if (call) begin
            if (!full) begin
                push    = !reset;
                pc_next = bus_in;
                sp_next = sp_reg + SP_W'(1);
            end else begin
                ovf_next = 1'b1;
            end
        end else if (jmp) begin
            pc_next = bus_in;
        end else if (ce) begin
            pc_next = pc_reg + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg      <= ADDR_W'(RESET_ADDR);
            sp_reg      <= '0;
            bus_out_reg <= '0;
            bus_oe_reg  <= 1'b0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            sp_reg      <= sp_next;
            bus_out_reg <= bus_out_next;
            bus_oe_reg  <= bus_oe_next;
            ovf_reg     <= ovf_next;
            unf_reg     <= unf_next;
        end
    end

    assign pc          = pc_reg;
    assign bus_out     = bus_out_reg;
    assign bus_oe      = bus_oe_reg;
    assign sp          = sp_reg;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf_err     = ovf_reg;
    assign unf_err     = unf_reg;
endmodule

// File: tb/tb_pc_call_stack.sv
// Directed-vector bench: the driver queues the hand-computed state expected after each
// edge; a negedge monitor pops and compares it against the DUT.
module tb_pc_call_stack;
    logic       clk = 1'b0;
    logic       reset = 1'b0, ce = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0, co = 1'b0;
    logic [3:0] bus_in = '0;
    logic [3:0] pc, bus_out;
    logic       bus_oe;
    logic [2:0] sp;
    logic       stack_full, stack_empty, ovf_err, unf_err;

    pc_call_stack #(.ADDR_W(4), .STACK_DEPTH(4), .RESET_ADDR(0)) dut (
        .clk(clk), .reset(reset), .ce(ce), .jmp(jmp), .call(call), .ret(ret), .co(co),
        .bus_in(bus_in), .pc(pc), .bus_out(bus_out), .bus_oe(bus_oe), .sp(sp),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {reset, ret, call, jmp, ce, co}
    localparam logic [5:0] NONE = 6'b000000, RST = 6'b100000, RET = 6'b010000,
                           CALL = 6'b001000, JMP = 6'b000100, CE = 6'b000010, CO = 6'b000001;

    typedef struct {
        string      name;
        logic [3:0] pc;
        logic [2:0] sp;
        logic [3:0] bo;
        logic       oe;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("txn %-10s pc=%0h sp=%0d bus_out=%0h bus_oe=%0b ovf=%0b unf=%0b",
                     e.name, pc, sp, bus_out, bus_oe, ovf_err, unf_err);
            chk(e.name, "pc", 32'(pc), 32'(e.pc));
            chk(e.name, "sp", 32'(sp), 32'(e.sp));
            chk(e.name, "bus_out", 32'(bus_out), 32'(e.bo));
            chk(e.name, "bus_oe", 32'(bus_oe), 32'(e.oe));
            chk(e.name, "ovf_err", 32'(ovf_err), 32'(e.ovf));
            chk(e.name, "unf_err", 32'(unf_err), 32'(e.unf));
            chk(e.name, "stack_full", 32'(stack_full), 32'(e.sp == 3'd4));
            chk(e.name, "stack_empty", 32'(stack_empty), 32'(e.sp == 3'd0));
        end
    end

    task automatic cyc(input string nm, input logic [5:0] s, input logic [3:0] bin,
                       input logic [3:0] epc, input logic [2:0] esp, input logic [3:0] ebo,
                       input logic eoe, input logic eovf, input logic eunf);
        exp_t e;
        {reset, ret, call, jmp, ce, co} = s;
        bus_in = bin;
        @(posedge clk);
        e.name = nm; e.pc = epc; e.sp = esp; e.bo = ebo; e.oe = eoe; e.ovf = eovf; e.unf = eunf;
        sb.push_back(e);
        #1;
    endtask

    initial begin
        // Reset state
        cyc("rst0", RST, 4'h0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("rst1", RST | CO | CALL, 4'h7, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        // 17 increments wrap 15 -> 0 with no flags
        for (int i = 1; i <= 17; i++)
            cyc("ce_wrap", CE, 4'h0, 4'(i % 16), 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        // co with ce drives the old PC one cycle later
        cyc("jmp5", JMP, 4'h5, 4'h5, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("co_ce", CO | CE, 4'h0, 4'h6, 3'd0, 4'h5, 1'b1, 1'b0, 1'b0);
        cyc("co_off", NONE, 4'h0, 4'h6, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        // Single call/return, co shows pre-call PC
        cyc("jmp3", JMP, 4'h3, 4'h3, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("call_a", CALL | CO, 4'hA, 4'hA, 3'd1, 4'h3, 1'b1, 1'b0, 1'b0);
        cyc("ret_a", RET, 4'h0, 4'h3, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        // Nest to full, overflow attempt, unwind
        cyc("call1", CALL, 4'h1, 4'h1, 3'd1, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("call2", CALL, 4'h2, 4'h2, 3'd2, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("call3", CALL, 4'h3, 4'h3, 3'd3, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("call4", CALL, 4'h4, 4'h4, 3'd4, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("call_ovf", CALL | CE, 4'h9, 4'h4, 3'd4, 4'h0, 1'b0, 1'b1, 1'b0);
        cyc("ret4", RET, 4'h0, 4'h3, 3'd3, 4'h0, 1'b0, 1'b1, 1'b0);
        cyc("ret3", RET, 4'h0, 4'h2, 3'd2, 4'h0, 1'b0, 1'b1, 1'b0);
        cyc("ret2", RET, 4'h0, 4'h1, 3'd1, 4'h0, 1'b0, 1'b1, 1'b0);
        cyc("ret1", RET, 4'h0, 4'h3, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0);
        // Underflow is sticky; counting continues
        cyc("ret_unf", RET, 4'h0, 4'h3, 3'd0, 4'h0, 1'b0, 1'b1, 1'b1);
        cyc("ce_a", CE, 4'h0, 4'h4, 3'd0, 4'h0, 1'b0, 1'b1, 1'b1);
        cyc("ce_b", CE, 4'h0, 4'h5, 3'd0, 4'h0, 1'b0, 1'b1, 1'b1);
        cyc("rst_clr", RST, 4'h0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        // Priority: ret > call > jmp > ce
        cyc("jmp7", JMP, 4'h7, 4'h7, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("call2b", CALL, 4'h2, 4'h2, 3'd1, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("all_strb", RET | CALL | JMP | CE | CO, 4'hC, 4'h7, 3'd0, 4'h2, 1'b1, 1'b0, 1'b0);
        cyc("jmp_ce", JMP | CE, 4'h8, 4'h8, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("call_jmp", CALL | JMP, 4'h4, 4'h4, 3'd1, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("ret_8", RET, 4'h0, 4'h8, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        // Reset mid-sequence empties the stack logically
        cyc("call5", CALL, 4'h5, 4'h5, 3'd1, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("rst_call", RST | CALL, 4'h9, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc("ret_empty", RET, 4'h0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1);
        cyc("idle", NONE, 4'h0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
